// File: rtl/echo_pkg.sv
// Shared definitions for the echo subtractor: fpu op codes, controller states
// and the default fpu timeout.
package echo_pkg;

  typedef enum logic [2:0] {
    FPU_ADD = 3'b000,
    FPU_SUB = 3'b001,
    FPU_MUL = 3'b010,
    FPU_DIV = 3'b011
  } fpu_op_e;

  typedef enum logic [2:0] {
    IDLE,
    MUL_ISSUE,
    MUL_WAIT,
    SUB_ISSUE,
    SUB_WAIT,
    DONE
  } state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

endpackage

// File: rtl/echo_subtractor_fpu.sv
// Double-precision add/sub/mul unit with one operation in flight. The result and
// a level ready appear two cycles after the enable pulse; ready drops on enable.
module fpu
  import echo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  rmode,
  input  logic [2:0]  fpu_op,
  input  logic [63:0] opa,
  input  logic [63:0] opb,
  output logic [63:0] out,
  output logic        ready
);

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  logic [63:0] opa_q, opb_q, result;
  logic [2:0]  op_q;
  logic [1:0]  rmode_q;
  logic        pend, rz;

  // Subnormals flush to zero; rz selects truncation, anything else is nearest-even.
  function automatic logic [63:0] fp_round(input logic s, input logic signed [13:0] e,
                                           input logic [52:0] m, input logic g,
                                           input logic st, input logic trunc);
    logic [53:0]        mr;
    logic [51:0]        f;
    logic signed [13:0] er;
    mr = {1'b0, m} + 54'(~trunc & g & (st | m[0]));
    er = mr[53] ? e + 14'sd1 : e;
    f  = mr[53] ? mr[52:1] : mr[51:0];
    if (er >= 14'sd2047)   return {s, 11'h7FF, 52'h0};
    else if (er <= 14'sd0) return {s, 63'h0};
    else                   return {s, er[10:0], f};
  endfunction

  function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b,
                                         input logic trunc);
    logic               s;
    logic [105:0]       p;
    logic signed [13:0] e;
    s = a[63] ^ b[63];
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return QNAN;
    if (a[62:52] == 11'h0 || b[62:52] == 11'h0)     return {s, 63'h0};
    p = 106'({1'b1, a[51:0]}) * 106'({1'b1, b[51:0]});
    e = $signed({3'b000, a[62:52]}) + $signed({3'b000, b[62:52]}) - 14'sd1023;
    if (p[105]) return fp_round(s, e + 14'sd1, p[105:53], p[52], |p[51:0], trunc);
    else        return fp_round(s, e, p[104:52], p[51], |p[50:0], trunc);
  endfunction

  function automatic logic [63:0] fp_add(input logic [63:0] a, input logic [63:0] b_in,
                                         input logic negate_b, input logic trunc);
    logic [63:0]        b, big, sml;
    logic [10:0]        d;
    logic [5:0]         dc;
    logic [111:0]       sh;
    logic [55:0]        mb, ms;
    logic [56:0]        r;
    logic signed [13:0] e;
    logic               found;
    int                 lz;
    b = {b_in[63] ^ negate_b, b_in[62:0]};
    if (a[62:52] == 11'h7FF || b[62:52] == 11'h7FF) return QNAN;
    if (a[62:52] == 11'h0) return (b[62:52] == 11'h0) ? {a[63] & b[63], 63'h0} : b;
    if (b[62:52] == 11'h0) return a;
    if (a[62:0] >= b[62:0]) begin big = a; sml = b; end
    else                    begin big = b; sml = a; end
    // Three extra low bits (guard/round/sticky) keep the alignment shift exact enough for RNE.
    d  = big[62:52] - sml[62:52];
    dc = (d > 11'd63) ? 6'd63 : d[5:0];
    mb = {1'b1, big[51:0], 3'b000};
    sh = {1'b1, sml[51:0], 3'b000, 56'h0} >> dc;
    ms = {sh[111:57], sh[56] | (|sh[55:0])};
    r  = (big[63] == sml[63]) ? {1'b0, mb} + {1'b0, ms} : {1'b0, mb} - {1'b0, ms};
    if (r == 57'h0) return 64'h0;
    e = $signed({3'b000, big[62:52]});
    if (r[56]) begin
      r = {1'b0, r[56:2], r[1] | r[0]};
      e = e + 14'sd1;
    end else begin
      lz = 0;
      found = 1'b0;
      for (int i = 55; i >= 0; i--) begin
        if (!found && r[i]) begin
          lz = 55 - i;
          found = 1'b1;
        end
      end
      r = r << lz;
      e = e - $signed(14'(lz));
    end
    return fp_round(big[63], e, r[55:3], r[2], |r[1:0], trunc);
  endfunction

  assign rz = (rmode_q == 2'b01);

  // Division is not provided by this unit and returns a quiet NaN.
  always_comb begin
    case (op_q)
      FPU_ADD: result = fp_add(opa_q, opb_q, 1'b0, rz);
      FPU_SUB: result = fp_add(opa_q, opb_q, 1'b1, rz);
      FPU_MUL: result = fp_mul(opa_q, opb_q, rz);
      default: result = QNAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q   <= '0;
      opb_q   <= '0;
      op_q    <= '0;
      rmode_q <= '0;
      pend    <= 1'b0;
      ready   <= 1'b0;
      out     <= '0;
    end else if (enable) begin
      opa_q   <= opa;
      opb_q   <= opb;
      op_q    <= fpu_op;
      rmode_q <= rmode;
      pend    <= 1'b1;
      ready   <= 1'b0;
    end else if (pend) begin
      out   <= result;
      ready <= 1'b1;
      pend  <= 1'b0;
    end
  end

endmodule

// File: rtl/echo_subtractor.sv
// Echo removal: out_error = signal_align - gain*signal_lag on one time-shared fpu.
// Latency 4+Tmul+Tsub cycles (2 in bypass); in_valid edges while busy are dropped and flag overrun.
module echo_subtractor
  import echo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter logic [1:0]  RMODE          = 2'b00
) (
  input  logic        clk_operation,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] signal_lag,
  input  logic [63:0] signal_align,
  input  logic [63:0] gain,
  input  logic        bypass,
  output logic [63:0] out_error,
  output logic        out_valid,
  output logic        busy,
  output logic        overrun,
  output logic        timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state;
  logic        in_valid_q, rise, guard, expired;
  logic [63:0] lag_q, align_q, gain_q, prod_q;
  logic [CW-1:0] wait_cnt;

  logic        fpu_en, fpu_ready;
  fpu_op_e     fpu_op;
  logic [63:0] fpu_opa, fpu_opb, fpu_out;

  assign rise    = in_valid & ~in_valid_q;
  assign busy    = (state != IDLE);
  // The fpu's ready is a level left over from the previous op, so the first wait cycle ignores it.
  assign guard   = (wait_cnt == '0);
  assign expired = (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    fpu_en  = 1'b0;
    fpu_op  = FPU_MUL;
    fpu_opa = lag_q;
    fpu_opb = gain_q;
    if (state == MUL_ISSUE) begin
      fpu_en = 1'b1;
    end else if (state == SUB_ISSUE) begin
      fpu_en  = 1'b1;
      fpu_op  = FPU_SUB;
      fpu_opa = align_q;
      fpu_opb = prod_q;
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      state      <= IDLE;
      in_valid_q <= 1'b0;
      out_error  <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
      wait_cnt   <= '0;
      lag_q      <= '0;
      align_q    <= '0;
      gain_q     <= '0;
      prod_q     <= '0;
    end else begin
      in_valid_q <= in_valid;
      out_valid  <= 1'b0;
      if (rise && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (rise) begin
            if (bypass) begin
              out_error <= signal_align;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              lag_q   <= signal_lag;
              align_q <= signal_align;
              gain_q  <= gain;
              state   <= MUL_ISSUE;
            end
          end
        end
        MUL_ISSUE: begin
          wait_cnt <= '0;
          state    <= MUL_WAIT;
        end
        MUL_WAIT: begin
          if (!guard && fpu_ready) begin
            prod_q <= fpu_out;
            state  <= SUB_ISSUE;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        SUB_ISSUE: begin
          wait_cnt <= '0;
          state    <= SUB_WAIT;
        end
        SUB_WAIT: begin
          if (!guard && fpu_ready) begin
            out_error <= fpu_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (expired) begin
            timeout <= 1'b1;
            state   <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fpu u_fpu (
    .clk    (clk_operation),
    .rst    (rst),
    .enable (fpu_en),
    .rmode  (RMODE),
    .fpu_op (fpu_op),
    .opa    (fpu_opa),
    .opb    (fpu_opb),
    .out    (fpu_out),
    .ready  (fpu_ready)
  );

endmodule
